// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
// Holds the FSM state enum, owner encoding and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin selector.
// Ports: a_valid/b_valid requests, last_b last grant was b, pick_a/pick_b one-hot grant.
module rr_pick (
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_b,
  output logic pick_a,
  output logic pick_b
);

  // On a conflict, favour whoever did not win last time.
  assign pick_a = a_valid && (!b_valid || last_b);
  assign pick_b = b_valid && (!a_valid || !last_b);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port.
// Ports: clk/rst, if_* fetch req/resp, ls_* load/store req/resp, men..rdata memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              men,
  output logic              mwen,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wmask,
  input  logic [DATA_W-1:0] rdata
);

  state_t state;
  owner_t last_gnt;
  owner_t owner;
  logic [DATA_W-1:0] resp_q;
  logic pick_if;
  logic pick_ls;
  logic gnt_if;
  logic gnt_ls;

  rr_pick u_pick (
    .a_valid (if_req_valid),
    .b_valid (ls_req_valid),
    .last_b  (last_gnt == OWN_LS),
    .pick_a  (pick_if),
    .pick_b  (pick_ls)
  );

  // Grants only exist in IDLE and never while reset is held.
  assign gnt_if = pick_if && (state == IDLE) && !rst;
  assign gnt_ls = pick_ls && (state == IDLE) && !rst;

  assign if_req_ready = gnt_if;
  assign ls_req_ready = gnt_ls;
  assign if_rdata = resp_q;
  assign ls_rdata = resp_q;

  // Memory port registers double as the latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_gnt      <= OWN_IF;
      owner         <= OWN_IF;
      men           <= 1'b0;
      mwen          <= 1'b0;
      raddr         <= '0;
      waddr         <= '0;
      wdata         <= '0;
      wmask         <= '0;
      resp_q        <= '0;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_if) begin
            state    <= ACCESS;
            owner    <= OWN_IF;
            last_gnt <= OWN_IF;
            men      <= 1'b1;
            raddr    <= if_addr;
          end else if (gnt_ls) begin
            state    <= ACCESS;
            owner    <= OWN_LS;
            last_gnt <= OWN_LS;
            men      <= 1'b1;
            mwen     <= ls_wen;
            if (ls_wen) begin
              waddr <= ls_addr;
              wdata <= ls_wdata;
              wmask <= ls_wmask;
            end else begin
              raddr <= ls_addr;
            end
          end
        end
        ACCESS: begin
          state         <= RESP;
          men           <= 1'b0;
          mwen          <= 1'b0;
          raddr         <= '0;
          waddr         <= '0;
          wdata         <= '0;
          wmask         <= '0;
          resp_q        <= mwen ? '0 : rdata;
          if_resp_valid <= (owner == OWN_IF);
          ls_resp_valid <= (owner == OWN_LS);
        end
        RESP: begin
          state         <= IDLE;
          if_resp_valid <= 1'b0;
          ls_resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level model.
// Directed scenarios first, then random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_resp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic        ls_wen = 1'b0;
  logic [63:0] ls_addr = '0;
  logic [63:0] ls_wdata = '0;
  logic [7:0]  ls_wmask = '0;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic        men;
  logic        mwen;
  logic [63:0] raddr;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [63:0] rdata;

  int checks = 0;
  int errors = 0;

  // Model: cycles since accept (0 = free), who owns it, what it asked.
  int          phase = 0;
  bit          last_ls = 0;
  bit          cur_ls = 0;
  bit          cur_wen = 0;
  logic [63:0] cur_addr = '0;
  logic [63:0] cur_wdata = '0;
  logic [7:0]  cur_wmask = '0;
  logic [63:0] exp_resp = '0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0413;
    return {~a[31:0], a[63:32] ^ 32'h1234_5678};
  endfunction

  assign rdata = mem_val(raddr);

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_resp_valid (if_resp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_wen        (ls_wen),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_rdata      (ls_rdata),
    .men           (men),
    .mwen          (mwen),
    .raddr         (raddr),
    .waddr         (waddr),
    .wdata         (wdata),
    .wmask         (wmask),
    .rdata         (rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic raise_if(input logic [63:0] a);
    if_req_valid = 1'b1;
    if_addr = a;
  endtask

  task automatic raise_ls(input bit w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] m);
    ls_req_valid = 1'b1;
    ls_wen = w;
    ls_addr = a;
    ls_wdata = d;
    ls_wmask = m;
  endtask

  // Called just after a negedge with inputs set; ends at next negedge.
  task automatic step();
    bit acc_if;
    bit acc_ls;
    bit wr;
    #1;
    acc_if = 0;
    acc_ls = 0;
    if (phase == 0) begin
      if (if_req_valid && ls_req_valid) begin
        acc_ls = !last_ls;
        acc_if = last_ls;
      end else begin
        acc_if = if_req_valid;
        acc_ls = ls_req_valid;
      end
    end
    chk("if_ready", if_req_ready, acc_if);
    chk("ls_ready", ls_req_ready, acc_ls);
    wr = cur_ls && cur_wen;
    if (phase == 1) begin
      chk("men", men, 1);
      chk("mwen", mwen, wr);
      chk("raddr", raddr, wr ? 64'd0 : cur_addr);
      chk("waddr", waddr, wr ? cur_addr : 64'd0);
      chk("wdata", wdata, wr ? cur_wdata : 64'd0);
      chk("wmask", wmask, wr ? cur_wmask : 8'd0);
    end else begin
      chk("men_off", men, 0);
      chk("mwen_off", mwen, 0);
      chk("port_off", raddr | waddr | wdata | 64'(wmask), 0);
    end
    chk("if_resp", if_resp_valid, phase == 2 && !cur_ls);
    chk("ls_resp", ls_resp_valid, phase == 2 && cur_ls);
    if (phase == 2)
      chk("rdata", cur_ls ? ls_rdata : if_rdata, exp_resp);
    @(posedge clk);
    #1;
    if (phase == 1) begin
      exp_resp = wr ? 64'd0 : mem_val(cur_addr);
      phase = 2;
    end else if (phase == 2) begin
      phase = 0;
    end else if (acc_if || acc_ls) begin
      phase = 1;
      cur_ls = acc_ls;
      last_ls = acc_ls;
      cur_wen = acc_ls && ls_wen;
      cur_addr = acc_ls ? ls_addr : if_addr;
      cur_wdata = ls_wdata;
      cur_wmask = ls_wmask;
      if (acc_if) if_req_valid = 1'b0;
      if (acc_ls) ls_req_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2;
    chk("rst_men", men, 0);
    chk("rst_rdy", {if_req_ready, ls_req_ready}, 0);
    chk("rst_resp", {if_resp_valid, ls_resp_valid}, 0);
    chk("rst_rdata", if_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Conflicting traffic from reset: LS, IF, LS, IF.
    for (int i = 0; i < 12; i++) begin
      if (!if_req_valid) raise_if(64'h1000 + 64'(i * 8));
      if (!ls_req_valid)
        raise_ls(i[2], 64'h2000 + 64'(i * 8), 64'(i) * 64'h1111, 8'hF0);
      step();
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    idle(3);

    // Lone fetch with a known instruction word.
    raise_if(64'h8000_0000);
    idle(4);

    // Lone masked write.
    raise_ls(1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F);
    idle(4);

    // LS shows up while IF owns the port and must wait.
    raise_if(64'h8000_0000);
    step();
    raise_ls(0, 64'h8000_2000, 64'h0, 8'h0);
    idle(5);

    // Reset in the middle of an access kills it.
    raise_ls(1, 64'h8000_3000, 64'h1234, 8'hFF);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_men", men, 0);
    chk("rst_mid_mwen", mwen, 0);
    chk("rst_mid_rdy", {if_req_ready, ls_req_ready}, 0);
    phase = 0;
    last_ls = 0;
    exp_resp = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_rdata", ls_rdata, 0);
    idle(3);
    raise_if(64'h8000_0000);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!if_req_valid && $urandom_range(0, 2) == 0)
        raise_if({$urandom, $urandom});
      if (!ls_req_valid && $urandom_range(0, 2) == 0)
        raise_ls(1'($urandom_range(0, 1)), {$urandom, $urandom},
                 {$urandom, $urandom}, 8'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
